// File: rtl/instruction_fetch.sv
// Program counter and fetch sequencer for the instruction ROM.
// Registers each fetched word with its PC and a valid flag for decode.
//
// state   | meaning
// S_IDLE  | waiting for start, nothing valid
// S_FETCH | presenting pc to ROM and registering one word per clock
// S_DONE  | program finished or branched out of range; done high
module instruction_fetch #(
  parameter int NUM_INSTR = 66,
  parameter int ADDR_W    = 7,
  parameter int INSTR_W   = 9
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_instruction,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(NUM_INSTR - 1);
  localparam logic [ADDR_W:0]   NUM_W   = (ADDR_W + 1)'(NUM_INSTR);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic [ADDR_W-1:0]  ipc_nxt;
  logic               valid_nxt;
  logic               target_ok;

  // Widened compare so a target equal to 2**ADDR_W-1 is still tested correctly
  assign target_ok   = ({1'b0, branch_target} < NUM_W);
  assign rom_address = pc;
  assign done        = (state == S_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      instruction <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instruction <= instr_nxt;
      instr_pc    <= ipc_nxt;
      instr_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instruction;
    ipc_nxt   = instr_pc;
    valid_nxt = instr_valid;
    case (state)
      S_IDLE, S_DONE: begin
        // Clearing valid here makes the last word visible for exactly one cycle
        valid_nxt = 1'b0;
        if (start) begin
          pc_nxt    = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (branch_taken) begin
          valid_nxt = 1'b0;
          if (target_ok) pc_nxt = branch_target;
          else           state_nxt = S_DONE;
        end else if (!stall) begin
          instr_nxt = rom_instruction;
          ipc_nxt   = pc;
          valid_nxt = 1'b1;
          if (pc == LAST_PC) state_nxt = S_DONE;
          else               pc_nxt = pc + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: ROM model, reference model,
// per-cycle compare plus directed literal checks.
module tb_instruction_fetch;

  localparam int N = 66;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       branch_taken = 1'b0;
  logic [6:0] branch_target = '0;
  logic [6:0] rom_address;
  logic [8:0] rom_instruction;
  logic [8:0] instruction;
  logic [6:0] instr_pc;
  logic       instr_valid;
  logic       done;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  instruction_fetch dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .rom_address(rom_address), .rom_instruction(rom_instruction),
    .instruction(instruction), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] rom_f(input logic [6:0] a);
    return 9'((int'(a) * 37 + 5) % 512);
  endfunction

  assign rom_instruction = rom_f(rom_address);

  // Reference model: 0 = idle, 1 = fetching, 2 = finished
  int         m_mode;
  logic [6:0] m_pc, m_ipc;
  logic [8:0] m_ins;
  bit         m_v;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= 0; m_pc <= 0; m_ipc <= 0; m_ins <= 0; m_v <= 0;
    end else if (m_mode == 1) begin
      if (branch_taken) begin
        m_v <= 0;
        if (int'(branch_target) < N) m_pc <= branch_target;
        else                         m_mode <= 2;
      end else if (!stall) begin
        m_ins <= rom_f(m_pc);
        m_ipc <= m_pc;
        m_v   <= 1;
        if (int'(m_pc) == N - 1) m_mode <= 2;
        else                     m_pc <= m_pc + 7'd1;
      end
    end else begin
      m_v <= 0;
      if (start) begin
        m_pc <= 0;
        m_mode <= 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      chk("cyc_rom_address", int'(rom_address), int'(m_pc));
      chk("cyc_instr_valid", int'(instr_valid), int'(m_v));
      chk("cyc_done", int'(done), int'(m_mode == 2));
      if (m_v) begin
        chk("cyc_instr_pc", int'(instr_pc), int'(m_ipc));
        chk("cyc_instruction", int'(instruction), int'(m_ins));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int nvalid;
  bit finished;

  initial begin
    // Reset values
    #12;
    chk("rst_rom_address", int'(rom_address), 0);
    chk("rst_instr_valid", int'(instr_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_instr_pc", int'(instr_pc), 0);
    chk("rst_instruction", int'(instruction), 0);
    reset_n = 1'b1;
    check_en = 1'b1;
    tick();
    chk("idle_no_valid", int'(instr_valid), 0);

    // 1: full program run
    pulse_start();
    chk("t1_pc0", int'(rom_address), 0);
    nvalid = 0;
    finished = 0;
    for (int i = 0; i < 100 && !finished; i++) begin
      tick();
      if (instr_valid) begin
        chk("t1_seq_pc", int'(instr_pc), nvalid);
        chk("t1_seq_word", int'(instruction), int'(rom_f(7'(nvalid))));
        nvalid++;
      end
      if (done) finished = 1;
    end
    chk("t1_done_reached", int'(finished), 1);
    chk("t1_valid_count", nvalid, 66);
    chk("t1_last_pc", int'(instr_pc), 65);
    chk("t1_last_valid", int'(instr_valid), 1);
    tick();
    chk("t1_after_valid", int'(instr_valid), 0);
    chk("t1_after_done", int'(done), 1);
    chk("t1_hold_pc", int'(instr_pc), 65);

    // 2: stall for 3 cycles at pc=10
    pulse_start();
    chk("t2_done_falls", int'(done), 0);
    repeat (10) tick();
    chk("t2_pc10", int'(rom_address), 10);
    chk("t2_ipc9", int'(instr_pc), 9);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stall_ipc", int'(instr_pc), 9);
      chk("t2_stall_valid", int'(instr_valid), 1);
      chk("t2_stall_pc", int'(rom_address), 10);
    end
    stall = 1'b0;
    tick();
    chk("t2_resume_ipc", int'(instr_pc), 10);
    chk("t2_resume_word", int'(instruction), int'(rom_f(7'd10)));

    // 3: branch to 3 at pc=20
    repeat (9) tick();
    chk("t3_pc20", int'(rom_address), 20);
    branch_taken = 1'b1;
    branch_target = 7'd3;
    tick();
    branch_taken = 1'b0;
    chk("t3_squash", int'(instr_valid), 0);
    tick();
    chk("t3_ipc3", int'(instr_pc), 3);
    chk("t3_valid3", int'(instr_valid), 1);
    tick();
    chk("t3_ipc4", int'(instr_pc), 4);

    // 5: branch and stall together at pc=5
    chk("t5_pc5", int'(rom_address), 5);
    branch_taken = 1'b1;
    stall = 1'b1;
    branch_target = 7'd40;
    tick();
    branch_taken = 1'b0;
    stall = 1'b0;
    chk("t5_squash", int'(instr_valid), 0);
    chk("t5_pc40", int'(rom_address), 40);
    tick();
    chk("t5_ipc40", int'(instr_pc), 40);
    chk("t5_word40", int'(instruction), int'(rom_f(7'd40)));

    // 4: out-of-range branch ends the program
    branch_taken = 1'b1;
    branch_target = 7'd100;
    tick();
    branch_taken = 1'b0;
    chk("t4_valid", int'(instr_valid), 0);
    chk("t4_done", int'(done), 1);
    tick();
    chk("t4_done_hold", int'(done), 1);
    start = 1'b1;
    stall = 1'b1;
    tick();
    start = 1'b0;
    stall = 1'b0;
    chk("t4_restart_done", int'(done), 0);

    // boundary: branch to the last legal PC
    branch_taken = 1'b1;
    branch_target = 7'd65;
    tick();
    branch_taken = 1'b0;
    chk("edge_pc65", int'(rom_address), 65);
    chk("edge_done_low", int'(done), 0);
    tick();
    chk("edge_ipc65", int'(instr_pc), 65);
    chk("edge_done", int'(done), 1);

    // 6: async reset mid-program
    pulse_start();
    repeat (30) tick();
    chk("t6_pc30", int'(rom_address), 30);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_addr", int'(rom_address), 0);
    chk("t6_rst_valid", int'(instr_valid), 0);
    chk("t6_rst_ipc", int'(instr_pc), 0);
    chk("t6_rst_instr", int'(instruction), 0);
    chk("t6_rst_done", int'(done), 0);
    #3;
    reset_n = 1'b1;
    tick();
    tick();
    chk("t6_idle_addr", int'(rom_address), 0);
    chk("t6_idle_valid", int'(instr_valid), 0);
    pulse_start();
    tick();
    chk("t6_ipc0", int'(instr_pc), 0);
    chk("t6_valid0", int'(instr_valid), 1);
    tick();

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
